// File: rtl/immediate_decode_stage.sv
// immediate_decode_stage: extends the 16-bit immediate and computes the branch target
// behind a one-deep skid buffer so the input handshake is fully registered.
module immediate_decode_stage #(
   parameter bit ZEXT_LOGIC = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] instruction_i,
   input  logic [31:0] pc_plus4_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] imm_ext_o,
   output logic [31:0] branch_target_o,
   output logic [1:0]  ext_mode_o
);
   logic [5:0]  opcode;
   logic [15:0] imm;
   logic [31:0] sext, new_imm, new_bt;
   logic [1:0]  new_mode;
   logic        is_logic, is_lui, accept, emit;
   logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic [31:0] out_imm_q, out_imm_d, out_bt_q, out_bt_d;
   logic [31:0] skid_imm_q, skid_imm_d, skid_bt_q, skid_bt_d;
   logic [1:0]  out_mode_q, out_mode_d, skid_mode_q, skid_mode_d;

   assign opcode   = instruction_i[31:26];
   assign imm      = instruction_i[15:0];
   assign sext     = {{16{imm[15]}}, imm};
   assign is_logic = opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E;
   assign is_lui   = opcode == 6'h0F;
   assign new_mode = is_lui ? 2'b10 : (is_logic && ZEXT_LOGIC) ? 2'b01 : 2'b00;
   assign new_imm  = new_mode == 2'b10 ? {imm, 16'h0000} :
                     new_mode == 2'b01 ? {16'h0000, imm} : sext;
   assign new_bt   = pc_plus4_i + {sext[29:0], 2'b00};

   assign in_ready_o      = !skid_valid_q && !flush_i && !reset_i;
   assign accept          = in_valid_i && in_ready_o;
   assign emit            = out_valid_q && out_ready_i;
   assign out_valid_o     = out_valid_q;
   assign imm_ext_o       = out_imm_q;
   assign branch_target_o = out_bt_q;
   assign ext_mode_o      = out_mode_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_imm_d    = out_imm_q;
      out_bt_d     = out_bt_q;
      out_mode_d   = out_mode_q;
      skid_imm_d   = skid_imm_q;
      skid_bt_d    = skid_bt_q;
      skid_mode_d  = skid_mode_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (emit && skid_valid_q) begin
         // accept is impossible here since in_ready is low while the skid is full
         out_imm_d    = skid_imm_q;
         out_bt_d     = skid_bt_q;
         out_mode_d   = skid_mode_q;
         skid_valid_d = 1'b0;
      end else if (accept && (!out_valid_q || emit)) begin
         out_valid_d = 1'b1;
         out_imm_d   = new_imm;
         out_bt_d    = new_bt;
         out_mode_d  = new_mode;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = new_imm;
         skid_bt_d    = new_bt;
         skid_mode_d  = new_mode;
      end else if (emit) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_imm_q    <= '0;
         out_bt_q     <= '0;
         out_mode_q   <= 2'b00;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_imm_q    <= out_imm_d;
         out_bt_q     <= out_bt_d;
         out_mode_q   <= out_mode_d;
      end
      skid_imm_q  <= skid_imm_d;
      skid_bt_q   <= skid_bt_d;
      skid_mode_q <= skid_mode_d;
   end
endmodule

// File: tb/tb_immediate_decode_stage.sv
// tb_immediate_decode_stage: directed vectors with hand-computed expectations,
// one instance per ZEXT_LOGIC setting sharing the same stimulus.
module tb_immediate_decode_stage;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] instr, pc;
   logic        in_ready, out_valid, in_ready0, out_valid0;
   logic [31:0] imm_ext, bt, imm_ext0, bt0;
   logic [1:0]  mode, mode0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   immediate_decode_stage #(.ZEXT_LOGIC(1'b1)) dut (
      .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .instruction_i(instr), .pc_plus4_i(pc),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .imm_ext_o(imm_ext),
      .branch_target_o(bt), .ext_mode_o(mode));

   immediate_decode_stage #(.ZEXT_LOGIC(1'b0)) dut0 (
      .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready0), .instruction_i(instr), .pc_plus4_i(pc),
      .out_valid_o(out_valid0), .out_ready_i(out_ready), .imm_ext_o(imm_ext0),
      .branch_target_o(bt0), .ext_mode_o(mode0));

   function automatic logic [31:0] ins(input logic [5:0] op, input logic [15:0] im);
      return {op, 10'd0, im};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
      in_valid = v;
      instr    = i;
      pc       = p;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_imm", imm_ext, 32'h0);
      check("rst_bt", bt, 32'h0);
      check("rst_mode", 32'(mode), 32'd0);
      reset = 1'b0;
      #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

      out_ready = 1'b1;
      drive(1'b1, ins(6'h08, 16'hFFF0), 32'h0000_0100);
      tick();
      check("addi_valid", 32'(out_valid), 32'd1);
      check("addi_imm", imm_ext, 32'hFFFF_FFF0);
      check("addi_mode", 32'(mode), 32'd0);
      check("addi_bt", bt, 32'h0000_00C0);

      drive(1'b1, ins(6'h0D, 16'h8001), 32'h0);
      tick();
      check("ori_imm_z1", imm_ext, 32'h0000_8001);
      check("ori_mode_z1", 32'(mode), 32'd1);
      check("ori_imm_z0", imm_ext0, 32'hFFFF_8001);
      check("ori_mode_z0", 32'(mode0), 32'd0);
      check("ori_bt", bt, 32'hFFFE_0004);

      drive(1'b1, ins(6'h0F, 16'h1234), 32'h0);
      tick();
      check("lui_imm", imm_ext, 32'h1234_0000);
      check("lui_mode", 32'(mode), 32'd2);
      check("lui_mode_z0", 32'(mode0), 32'd2);

      drive(1'b1, ins(6'h04, 16'h0002), 32'hFFFF_FFFC);
      tick();
      check("beq_wrap_bt", bt, 32'h0000_0004);
      check("beq_imm", imm_ext, 32'h0000_0002);

      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("drain_valid", 32'(out_valid), 32'd0);

      // backpressure: A into output, B into skid, C refused
      out_ready = 1'b0;
      drive(1'b1, ins(6'h08, 16'h0001), 32'h10);
      tick();
      check("bp_a_valid", 32'(out_valid), 32'd1);
      check("bp_a_imm", imm_ext, 32'h1);
      check("bp_a_bt", bt, 32'h14);
      check("bp_ready_after_a", 32'(in_ready), 32'd1);
      drive(1'b1, ins(6'h08, 16'h0002), 32'h20);
      tick();
      check("bp_hold_a", imm_ext, 32'h1);
      check("bp_full_ready", 32'(in_ready), 32'd0);
      drive(1'b1, ins(6'h08, 16'h0003), 32'h30);
      tick();
      check("bp_c_refused_hold", imm_ext, 32'h1);
      check("bp_c_refused_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      check("bp_b_out", imm_ext, 32'h2);
      check("bp_b_bt", bt, 32'h28);
      check("bp_b_valid", 32'(out_valid), 32'd1);
      check("bp_ready_again", 32'(in_ready), 32'd1);
      tick();
      check("bp_c_out", imm_ext, 32'h3);
      check("bp_c_bt", bt, 32'h3C);
      check("bp_c_skid_empty", 32'(in_ready), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("bp_drained", 32'(out_valid), 32'd0);

      // flush with both entries full and a pending input
      out_ready = 1'b0;
      drive(1'b1, ins(6'h08, 16'h0004), 32'h40);
      tick();
      drive(1'b1, ins(6'h08, 16'h0005), 32'h50);
      tick();
      drive(1'b1, ins(6'h08, 16'h0006), 32'h60);
      flush = 1'b1;
      #1 check("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #1;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_skid_cleared", 32'(in_ready), 32'd1);
      check("flush_data_kept", imm_ext, 32'h4);
      tick();
      check("flush_nothing_accepted", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      drive(1'b1, ins(6'h08, 16'h0007), 32'h70);
      tick();
      check("post_flush_imm", imm_ext, 32'h7);
      check("post_flush_valid", 32'(out_valid), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      tick();

      // reset mid-stream with both entries full
      out_ready = 1'b0;
      drive(1'b1, ins(6'h0F, 16'h00AA), 32'h80);
      tick();
      drive(1'b1, ins(6'h0D, 16'h00BB), 32'h90);
      tick();
      reset = 1'b1;
      flush = 1'b1;
      drive(1'b1, ins(6'h08, 16'h00CC), 32'hA0);
      #1 check("midrst_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_imm", imm_ext, 32'h0);
      check("midrst_bt", bt, 32'h0);
      check("midrst_mode", 32'(mode), 32'd0);
      reset = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #1 check("midrst_ready_after", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      drive(1'b1, ins(6'h08, 16'h0008), 32'hB0);
      tick();
      check("midrst_first_imm", imm_ext, 32'h8);
      check("midrst_first_valid", 32'(out_valid), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("midrst_no_stale", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/immediate_decode_stage.md
IMMEDIATE_DECODE_STAGE -- requirements
Module: immediate_decode_stage

Interface
REQ-001 The block SHALL have parameter ZEXT_LOGIC, default 1: 1 = ANDI/ORI/XORI immediates zero-extended; 0 = all non-LUI immediates sign-extended.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Flush  input  1  synchronous pipeline flush (branch/jump redirect).
REQ-005 InValid  input  1  upstream (IF/ID) presents a valid instruction.
REQ-006 InReady  output  1  block can accept; combinational = !SkidValid && !Flush && !Reset.
REQ-007 Instruction  input  32  instruction word; opcode [31:26], immediate [15:0].
REQ-008 PCPlus4  input  32  PC+4 of the instruction.
REQ-009 OutValid  output  1  registered; ImmExt/BranchTarget/ExtMode valid.
REQ-010 OutReady  input  1  downstream (ID/EX) accepts the output this cycle.
REQ-011 ImmExt  output  32  extended immediate.
REQ-012 BranchTarget  output  32  PCPlus4 + (sign-extended immediate << 2).
REQ-013 ExtMode  output  2  00 sign-extend, 01 zero-extend, 10 LUI (upper).

Function
REQ-014 The block SHALL accept a transfer when InValid && InReady, and emit one when OutValid && OutReady.
REQ-015 The block SHALL select extension by opcode: 0x0C/0x0D/0x0E -> zero-extend ({16'b0, imm}) when ZEXT_LOGIC=1, else sign-extend; 0x0F -> {imm, 16'b0}; all others -> sign-extend ({16{imm[15]}, imm}).
REQ-016 The block SHALL always compute BranchTarget from the sign-extended immediate shifted left 2, added modulo 2^32 (carry out discarded), regardless of opcode.
REQ-017 The block SHALL hold state in two entries: output register (drives outputs) and one skid register (SkidValid).
REQ-018 The block SHALL have latency 1: an instruction accepted at edge N into an empty/draining output register is visible with OutValid=1 after edge N.
REQ-019 On accept, the block SHALL load the output register if it is empty or emitting this cycle; otherwise it SHALL load the skid register.
REQ-020 On emit with SkidValid=1, the block SHALL move the skid entry into the output register and clear SkidValid at the same edge.
REQ-021 Transfers SHALL leave in acceptance order; no entry dropped or duplicated.
REQ-022 While OutValid=1 && OutReady=0, output data SHALL hold stable.
REQ-023 Simultaneous emit and accept with output full, skid empty: the new entry SHALL replace the output register; SkidValid stays 0.
REQ-024 Full (both entries valid): InReady=0; InValid ignored.
REQ-025 Flush=1 SHALL clear OutValid and SkidValid at the edge, override any accept/emit that cycle, and leave data registers unchanged.
REQ-026 Data registers SHALL load only on accept or skid-to-output move.

Reset
REQ-027 Reset=1 at an edge SHALL set OutValid=0, SkidValid=0, ImmExt=0, BranchTarget=0, ExtMode=00, taking priority over Flush, accept and emit.
REQ-028 Reset asserted mid-operation SHALL discard both buffered entries; first accept after Reset deasserts behaves as from empty.
REQ-029 InReady SHALL be 0 while Reset=1 and 1 the first cycle after (absent Flush).

Verification
REQ-030 Sign: ADDI imm 0xFFF0, PCPlus4 0x00000100, OutReady=1 -> next cycle OutValid=1, ImmExt=0xFFFFFFF0, ExtMode=00, BranchTarget=0x000000C0.
REQ-031 Zero/LUI: ORI imm 0x8001 -> ImmExt=0x00008001, ExtMode=01 (ZEXT_LOGIC=1), 0xFFFF8001 (ZEXT_LOGIC=0); LUI imm 0x1234 -> ImmExt=0x12340000, ExtMode=10.
REQ-032 Backpressure: OutReady=0, three back-to-back InValid -> first two accepted, InReady=0 on third; raise OutReady -> outputs 1st then 2nd in order, third accepted once InReady=1.
REQ-033 Wrap: PCPlus4 0xFFFFFFFC, BEQ imm 0x0002 -> BranchTarget=0x00000004.
REQ-034 Flush with both entries full plus InValid=1 -> next cycle OutValid=0, SkidValid=0, nothing accepted.
REQ-035 Reset mid-stream with entries full -> next cycle OutValid=0, ImmExt=0, BranchTarget=0, ExtMode=00, InReady=1 after Reset drops.
